// File: rtl/spike_weight_accumulator.sv
// rtl/spike_weight_accumulator.sv - per-timestep float32 sum of spike weights for one neuron
module spike_weight_accumulator (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        clear,
    input  logic        spike_valid,
    input  logic [31:0] spike_weight,
    output logic        spike_ready,
    output logic [31:0] input_weight,
    output logic        weight_valid
);

    typedef enum logic [1:0] {IDLE, ALIGN, ADD, NORM} state_t;

    state_t             state;
    logic               clear_pending;
    logic [31:0]        acc;
    logic [31:0]        op_b;
    logic               sign_a;
    logic               sign_b;
    logic               res_sign;
    logic [23:0]        man_a;
    logic [23:0]        man_b;
    logic [24:0]        sum;
    logic signed [9:0]  exp_r;

    assign spike_ready = (state == IDLE) && !clear && !clear_pending;

    function automatic logic [4:0] lzc24(input logic [23:0] v);
        logic [4:0] n;
        n = 5'd24;
        for (int i = 0; i < 24; i++) begin
            if (v[i]) n = 5'(23 - i);
        end
        return n;
    endfunction

    // Alignment: exponent 0 reads as zero, the smaller operand is shifted right with truncation
    logic [7:0]  ea, eb, diff, al_exp;
    logic [23:0] ma, mb, al_a, al_b;
    always_comb begin
        ea = acc[30:23];
        eb = op_b[30:23];
        ma = (ea == 8'd0) ? 24'd0 : {1'b1, acc[22:0]};
        mb = (eb == 8'd0) ? 24'd0 : {1'b1, op_b[22:0]};
        if (ea >= eb) begin
            diff   = ea - eb;
            al_exp = ea;
            al_a   = ma;
            al_b   = (diff >= 8'd25) ? 24'd0 : (mb >> diff);
        end else begin
            diff   = eb - ea;
            al_exp = eb;
            al_a   = (diff >= 8'd25) ? 24'd0 : (ma >> diff);
            al_b   = mb;
        end
    end

    logic [24:0] add_sum;
    logic        add_sign;
    always_comb begin
        if (sign_a == sign_b) begin
            add_sum  = {1'b0, man_a} + {1'b0, man_b};
            add_sign = sign_a;
        end else if (man_a >= man_b) begin
            add_sum  = {1'b0, man_a} - {1'b0, man_b};
            add_sign = sign_a;
        end else begin
            add_sum  = {1'b0, man_b} - {1'b0, man_a};
            add_sign = sign_b;
        end
    end

    // A zero sum leaves the top mantissa bit clear after the shift, which doubles as the +0 case
    logic [4:0]        lz;
    logic [23:0]       mant;
    logic signed [9:0] ne;
    logic [31:0]       norm_res;
    always_comb begin
        lz = lzc24(sum[23:0]);
        if (sum[24]) begin
            mant = sum[24:1];
            ne   = exp_r + 10'sd1;
        end else begin
            mant = sum[23:0] << lz;
            ne   = exp_r - signed'({5'd0, lz});
        end
        if (!mant[23])
            norm_res = 32'h0000_0000;
        else if (ne >= 10'sd255)
            norm_res = {res_sign, 31'h7F7F_FFFF};
        else if (ne <= 10'sd0)
            norm_res = 32'h0000_0000;
        else
            norm_res = {res_sign, ne[7:0], mant[22:0]};
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state         <= IDLE;
            clear_pending <= 1'b0;
            acc           <= 32'd0;
            op_b          <= 32'd0;
            sign_a        <= 1'b0;
            sign_b        <= 1'b0;
            res_sign      <= 1'b0;
            man_a         <= 24'd0;
            man_b         <= 24'd0;
            sum           <= 25'd0;
            exp_r         <= 10'sd0;
            input_weight  <= 32'd0;
            weight_valid  <= 1'b0;
        end else begin
            weight_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (clear) begin
                        input_weight <= acc;
                        acc          <= 32'd0;
                        weight_valid <= 1'b1;
                    end else if (spike_valid && spike_ready) begin
                        op_b  <= spike_weight;
                        state <= ALIGN;
                    end
                end
                ALIGN: begin
                    sign_a <= acc[31];
                    sign_b <= op_b[31];
                    man_a  <= al_a;
                    man_b  <= al_b;
                    exp_r  <= signed'({2'b00, al_exp});
                    if (clear) clear_pending <= 1'b1;
                    state  <= ADD;
                end
                ADD: begin
                    sum      <= add_sum;
                    res_sign <= add_sign;
                    if (clear) clear_pending <= 1'b1;
                    state    <= NORM;
                end
                NORM: begin
                    if (clear || clear_pending) begin
                        input_weight  <= norm_res;
                        acc           <= 32'd0;
                        weight_valid  <= 1'b1;
                        clear_pending <= 1'b0;
                    end else begin
                        acc <= norm_res;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spike_weight_accumulator.sv
// tb/tb_spike_weight_accumulator.sv - table-driven and scoreboard bench for spike_weight_accumulator
module tb_spike_weight_accumulator;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        clear;
    logic        spike_valid;
    logic [31:0] spike_weight;
    logic        spike_ready;
    logic [31:0] input_weight;
    logic        weight_valid;

    spike_weight_accumulator dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .clear        (clear),
        .spike_valid  (spike_valid),
        .spike_weight (spike_weight),
        .spike_ready  (spike_ready),
        .input_weight (input_weight),
        .weight_valid (weight_valid)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] sum;
    } vec_t;

    int          vectors    = 0;
    int          miscompares = 0;
    logic [31:0] exp_q[$];
    logic        wv_prev = 1'b0;
    vec_t        tbl[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: every weight_valid pulse consumes one expected total
    always @(negedge CLK) begin
        if (weight_valid) begin
            if (exp_q.size() == 0)
                check("unexpected_weight_valid", {31'd0, weight_valid}, 32'd0);
            else
                check("input_weight", input_weight, exp_q.pop_front());
            if (wv_prev)
                check("weight_valid_width", {31'd0, weight_valid & wv_prev}, 32'd0);
        end
        wv_prev = weight_valid;
    end

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        while (!spike_ready && n < 40) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 40) check(name, {31'd0, spike_ready}, 32'd1);
    endtask

    task automatic send(input logic [31:0] w);
        @(negedge CLK);
        spike_valid  = 1'b1;
        spike_weight = w;
        wait_ready("send_timeout");
        @(negedge CLK);
        spike_valid = 1'b0;
    endtask

    task automatic do_clear(input logic [31:0] exp);
        @(negedge CLK);
        wait_ready("clear_timeout");
        clear = 1'b1;
        exp_q.push_back(exp);
        @(negedge CLK);
        clear = 1'b0;
    endtask

    initial begin
        tbl[0]  = '{32'h4120_0000, 32'h40B0_0000, 32'h4178_0000};
        tbl[1]  = '{32'h4120_0000, 32'hC120_0000, 32'h0000_0000};
        tbl[2]  = '{32'h4B80_0000, 32'h3F80_0000, 32'h4B80_0000};
        tbl[3]  = '{32'h7F7F_FFFF, 32'h7F7F_FFFF, 32'h7F7F_FFFF};
        tbl[4]  = '{32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000};
        tbl[5]  = '{32'h3F80_0000, 32'hBF00_0000, 32'h3F00_0000};
        tbl[6]  = '{32'hC040_0000, 32'h3F80_0000, 32'hC000_0000};
        tbl[7]  = '{32'h3F80_0000, 32'h3380_0000, 32'h3F80_0000};
        tbl[8]  = '{32'h3F80_0000, 32'h3400_0000, 32'h3F80_0001};
        tbl[9]  = '{32'h0000_0001, 32'h0000_0000, 32'h0000_0000};
        tbl[10] = '{32'h0080_0000, 32'h80C0_0000, 32'h0000_0000};

        RESET        = 1'b1;
        clear        = 1'b0;
        spike_valid  = 1'b0;
        spike_weight = 32'd0;
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK);
        check("reset_spike_ready", {31'd0, spike_ready}, 32'd1);
        check("reset_input_weight", input_weight, 32'd0);
        check("reset_weight_valid", {31'd0, weight_valid}, 32'd0);

        for (int i = 0; i < 11; i++) begin
            send(tbl[i].a);
            send(tbl[i].b);
            do_clear(tbl[i].sum);
        end

        // Clear during ALIGN while the next weight is held on the input
        send(32'h4120_0000);
        @(negedge CLK);
        spike_valid  = 1'b1;
        spike_weight = 32'h40B0_0000;
        wait_ready("midclear_timeout");
        @(negedge CLK);
        check("ready_in_align", {31'd0, spike_ready}, 32'd0);
        spike_weight = 32'h4040_0000;
        clear        = 1'b1;
        exp_q.push_back(32'h4178_0000);
        @(negedge CLK);
        clear = 1'b0;
        check("ready_in_add", {31'd0, spike_ready}, 32'd0);
        @(negedge CLK);
        check("ready_in_norm", {31'd0, spike_ready}, 32'd0);
        @(negedge CLK);
        check("ready_after_norm", {31'd0, spike_ready}, 32'd1);
        @(negedge CLK);
        spike_valid = 1'b0;
        do_clear(32'h4040_0000);

        // Reset during ADD
        @(negedge CLK);
        spike_valid  = 1'b1;
        spike_weight = 32'h40B0_0000;
        wait_ready("midreset_timeout");
        @(negedge CLK);
        spike_valid = 1'b0;
        @(negedge CLK);
        RESET = 1'b1;
        #1;
        check("midreset_spike_ready", {31'd0, spike_ready}, 32'd1);
        check("midreset_input_weight", input_weight, 32'd0);
        check("midreset_weight_valid", {31'd0, weight_valid}, 32'd0);
        @(negedge CLK);
        RESET = 1'b0;
        send(32'h4120_0000);
        do_clear(32'h4120_0000);

        for (int n = 0; n < 20 && exp_q.size() != 0; n++) @(negedge CLK);
        check("scoreboard_drained", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/spike_weight_accumulator.md
# spike_weight_accumulator

Sums the IEEE-754 single-precision synaptic weights of all spikes that arrive at one neuron during a timestep. At each timestep boundary it presents the total as `input_weight` to `potential_adder`. The block sits directly upstream of `potential_adder` and uses the same `clear` timestep pulse. It contains a multi-cycle floating-point adder driven by a small FSM and a valid/ready input handshake.

## Interface
- No parameters. Data width is fixed at 32 bits (IEEE-754 binary32).
- `CLK`  input  1  system clock; all state updates on the rising edge.
- `RESET`  input  1  asynchronous, active-high reset.
- `clear`  input  1  timestep boundary pulse, one cycle, shared with `potential_adder`.
- `spike_valid`  input  1  `spike_weight` holds a weight to accumulate.
- `spike_weight`  input  32  float weight of the incoming spike.
- `spike_ready`  output  1  block can accept a weight this cycle.
- `input_weight`  output  32  registered total for the previous timestep; drives `potential_adder`.
- `weight_valid`  output  1  one-cycle pulse when `input_weight` is updated.

## Operation
- Internal state: running sum `acc` (32-bit float), FSM state, `clear_pending` flag.
- FSM states:
  - IDLE → ALIGN on accept (`spike_valid & spike_ready`).
  - ALIGN → ADD → NORM → IDLE unconditionally.
- `spike_ready = (state == IDLE) & ~clear & ~clear_pending` (combinational).
- Accept: latch `spike_weight` as operand B; `acc` is operand A.
- ALIGN:
  - Unpack both operands with the hidden bit.
  - Exponent 0 is treated as zero (denormals flushed).
  - Right-shift the smaller-exponent mantissa by the exponent difference. A difference ≥ 25 makes that mantissa zero.
  - Extra bits shifted out are truncated.
- ADD: add the mantissas if the signs are equal. Otherwise subtract the smaller magnitude from the larger; the result takes the sign of the larger.
- NORM:
  - Carry-out: shift right 1 and increment the exponent.
  - Otherwise: left-shift by the leading-zero count and decrement the exponent.
  - Write the result to `acc`.
- Result rules:
  - Rounding is truncation (toward zero).
  - Exact cancellation gives +0 (32'h00000000).
  - Exponent ≥ 255 saturates to ±32'h7F7FFFFF.
  - Exponent ≤ 0 flushes to +0.
  - Inputs with exponent 255 (Inf/NaN) are unsupported and give undefined output.
- `clear` in IDLE (with no pending clear): `input_weight <= acc`, `acc <= 0`, `weight_valid <= 1`. `spike_ready` is low that cycle, so no weight is lost.
- `clear` in ALIGN/ADD/NORM: set `clear_pending`. When NORM completes:
  - `input_weight <=` the NORM result.
  - `acc <= 0`, `weight_valid <= 1`, `clear_pending <= 0`.
  - The in-flight weight counts toward the ending timestep.
- `clear` with `clear_pending` already set: no additional effect (single pending clear).

## Timing
- Reset values: `input_weight` = 0, `weight_valid` = 0, `spike_ready` = 1, `acc` = 0, state IDLE, `clear_pending` = 0.
- `RESET` asserted mid-operation aborts the add immediately and discards the operand.
- Accept at edge N:
  - ALIGN in cycle N+1, ADD in N+2, NORM in N+3.
  - `acc` is updated at edge N+4; `spike_ready` is high again in cycle N+4.
- Throughput: one weight per 4 cycles.
- `input_weight` changes only on a clear event and holds for the whole timestep.
- `weight_valid` is high for exactly the cycle after that update edge.
- Clear latency:
  - 1 cycle when IDLE.
  - From ALIGN, ADD or NORM: `input_weight` updates at the edge that ends NORM.
- `spike_valid` while `spike_ready` is low: the weight is held off; upstream must keep `spike_weight` stable until accepted.

## Test plan
- Sum and clear:
  - Stimulus: after reset, accept 32'h41200000 (10.0), then 32'h40B00000 (5.5); pulse `clear` in IDLE.
  - Response: `input_weight` = 32'h41780000 (15.5), `weight_valid` pulses once, next sum starts from 0.
- Cancellation:
  - Stimulus: accept 32'h41200000, then 32'hC1200000; clear.
  - Response: `input_weight` = 32'h00000000.
- Truncation:
  - Stimulus: accept 32'h4B800000 (2^24), then 32'h3F800000 (1.0); clear.
  - Response: `input_weight` = 32'h4B800000.
- Overflow:
  - Stimulus: accept 32'h7F7FFFFF twice; clear.
  - Response: `input_weight` = 32'h7F7FFFFF.
- Clear mid-add:
  - Stimulus: accept 10.0 and let it complete; accept 5.5 and pulse `clear` during ALIGN, holding `spike_valid` high.
  - Response: `spike_ready` stays low until NORM ends; `input_weight` = 32'h41780000; the next held weight is accepted into a zeroed `acc`.
- Reset mid-add:
  - Stimulus: assert `RESET` during ADD.
  - Response: all outputs return to reset values at once; a following 10.0 + clear gives 32'h41200000.
